// File: rtl/merge_pkg.sv
// rtl/merge_pkg.sv - shared types and constants for the 2-to-1 round-robin merge
package merge_pkg;

    // Tags the source of a beat. It is also the encoding of the round-robin pointer.
    typedef enum logic {
        SRC0 = 1'b0,
        SRC1 = 1'b1
    } src_e;

    // Number of entries in each per-input buffer.
    localparam int BUF_DEPTH = 2;

    // Width of the occupancy counter. It must hold the values 0..BUF_DEPTH.
    localparam int CNT_W = 2;

    // Returns the source that is not s. The arbiter uses it to alternate on ties.
    function automatic src_e other_src(input src_e s);
        return (s == SRC0) ? SRC1 : SRC0;
    endfunction

endpackage

// File: rtl/skid_fifo2.sv
// rtl/skid_fifo2.sv - two-entry in-order buffer placed in front of each merge input
module skid_fifo2
    import merge_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // A push when full or a pop when empty is dropped here. The parent never
    // issues one, and the guard keeps the pointers consistent if it ever did.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign head_data = mem[rd_ptr];

    // Pointer and occupancy tracking. The 1-bit pointers wrap from 1 to 0 on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end

    // Storage is never reset. Clearing count is enough to discard its contents.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/merge_2to1_rr.sv
// rtl/merge_2to1_rr.sv - recombines two valid/ready streams with round-robin arbitration and source tagging
module merge_2to1_rr
    import merge_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PRIO_INIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src
);

    // The first tie after reset goes to PRIO_INIT. To get that, the pointer
    // starts at the opposite source.
    localparam src_e PRIO_SRC = (PRIO_INIT != 0) ? SRC1 : SRC0;

    logic             push0;
    logic             push1;
    logic             pop0;
    logic             pop1;
    logic             empty0;
    logic             empty1;
    logic             full0;
    logic             full1;
    logic [WIDTH-1:0] head0;
    logic [WIDTH-1:0] head1;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    src_e             out_src_q;
    src_e             last_grant;

    logic             load;
    logic             grant_valid;
    src_e             grant_src;
    logic [WIDTH-1:0] grant_data;

    // Ready depends only on buffer occupancy and reset, so no input-to-ready loop exists.
    assign in0_ready = !rst && !full0;
    assign in1_ready = !rst && !full1;
    assign push0     = in0_valid && in0_ready;
    assign push1     = in1_valid && in1_ready;

    skid_fifo2 #(
        .WIDTH(WIDTH)
    ) u_buf0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push0),
        .push_data (in0_data),
        .pop       (pop0),
        .head_data (head0),
        .empty     (empty0),
        .full      (full0)
    );

    skid_fifo2 #(
        .WIDTH(WIDTH)
    ) u_buf1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push1),
        .push_data (in1_data),
        .pop       (pop1),
        .head_data (head1),
        .empty     (empty1),
        .full      (full1)
    );

    // Round-robin choice. It applies only when the output register can take a new beat.
    always_comb begin
        load        = !out_valid_q || out_ready;
        grant_valid = 1'b0;
        grant_src   = SRC0;
        if (load && !rst) begin
            if (!empty0 && !empty1) begin
                grant_valid = 1'b1;
                grant_src   = other_src(last_grant);
            end else if (!empty0) begin
                grant_valid = 1'b1;
                grant_src   = SRC0;
            end else if (!empty1) begin
                grant_valid = 1'b1;
                grant_src   = SRC1;
            end
        end
        grant_data = (grant_src == SRC1) ? head1 : head0;
        pop0       = grant_valid && (grant_src == SRC0);
        pop1       = grant_valid && (grant_src == SRC1);
    end

    // Output register and round-robin pointer. The pointer moves only on a real
    // grant, so an idle gap does not change the fairness order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= SRC0;
            last_grant  <= other_src(PRIO_SRC);
        end else if (load) begin
            if (grant_valid) begin
                out_valid_q <= 1'b1;
                out_data_q  <= grant_data;
                out_src_q   <= grant_src;
                last_grant  <= grant_src;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_merge_2to1_rr.sv
// tb/tb_merge_2to1_rr.sv - self-checking bench for merge_2to1_rr
module tb_merge_2to1_rr;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in0_valid = 1'b0;
    logic             in0_ready;
    logic [WIDTH-1:0] in0_data = '0;
    logic             in1_valid = 1'b0;
    logic             in1_ready;
    logic [WIDTH-1:0] in1_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
    logic             out_src;

    merge_2to1_rr #(
        .WIDTH     (WIDTH),
        .PRIO_INIT (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_data  (in0_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d0;
        logic [7:0] d1;
        logic [8:0] exp_a;
        logic [8:0] exp_b;
    } rr_vec_t;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic       ordy = 1'b1;
    logic [7:0] drv0[$];
    logic [7:0] drv1[$];
    logic [7:0] sb0[$];
    logic [7:0] sb1[$];
    logic [8:0] outlog[$];
    int         outcyc[$];
    rr_vec_t    vecs[4];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive from the stream queues, note the handshakes, cross the edge,
    // then update the scoreboard.
    task automatic tick();
        logic acc0, acc1, otx;
        in0_valid = (drv0.size() != 0);
        in0_data  = in0_valid ? drv0[0] : 8'h00;
        in1_valid = (drv1.size() != 0);
        in1_data  = in1_valid ? drv1[0] : 8'h00;
        out_ready = ordy;
        #1;
        acc0 = in0_valid && in0_ready;
        acc1 = in1_valid && in1_ready;
        otx  = out_valid && out_ready;
        if (otx) begin
            outlog.push_back({out_src, out_data});
            outcyc.push_back(cyc);
            if (out_src == 1'b0) begin
                if (sb0.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL spurious_src0: got data 0x%0h, expected no beat", out_data);
                end else begin
                    check("sb_src0", int'(out_data), int'(sb0.pop_front()));
                end
            end else begin
                if (sb1.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL spurious_src1: got data 0x%0h, expected no beat", out_data);
                end else begin
                    check("sb_src1", int'(out_data), int'(sb1.pop_front()));
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (acc0) sb0.push_back(drv0.pop_front());
        if (acc1) sb1.push_back(drv1.pop_front());
    endtask

    task automatic drain(input int n, input int bound);
        int k = 0;
        while (outlog.size() < n && k < bound) begin
            tick();
            k++;
        end
        check("drain_count", outlog.size(), n);
    endtask

    task automatic do_reset();
        drv0.delete();
        drv1.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb0.delete();
        sb1.delete();
        outlog.delete();
        outcyc.delete();
        #1;
    endtask

    function automatic logic [8:0] log_at(input int i);
        return (i < outlog.size()) ? outlog[i] : 9'h1FF;
    endfunction

    initial begin
        // Reset holds for 3 cycles with both inputs offering data.
        rst = 1'b1;
        ordy = 1'b1;
        drv0.push_back(8'hEE);
        drv1.push_back(8'hEF);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_in0_ready", int'(in0_ready), 0);
            check("rst_in1_ready", int'(in1_ready), 0);
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_out_data", int'(out_data), 0);
            check("rst_out_src", int'(out_src), 0);
        end
        check("rst_accepted0", sb0.size(), 0);
        check("rst_accepted1", sb1.size(), 0);
        drv0.delete();
        drv1.delete();
        rst = 1'b0;
        #1;
        check("post_rst_in0_ready", int'(in0_ready), 1);
        check("post_rst_in1_ready", int'(in1_ready), 1);

        // Latency on one path.
        ordy = 1'b1;
        drv0.push_back(8'hA5);
        tick();
        check("lat_not_yet", int'(out_valid), 0);
        tick();
        check("lat_valid", int'(out_valid), 1);
        check("lat_data", int'(out_data), 'hA5);
        check("lat_src", int'(out_src), 0);
        tick();
        check("lat_gone", int'(out_valid), 0);

        // Round-robin fairness starting from a fresh reset with PRIO_INIT=0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            vecs[i].d0    = 8'h10 + 8'(i);
            vecs[i].d1    = 8'h20 + 8'(i);
            vecs[i].exp_a = {1'b0, 8'h10 + 8'(i)};
            vecs[i].exp_b = {1'b1, 8'h20 + 8'(i)};
        end
        ordy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drv0.push_back(vecs[i].d0);
            drv1.push_back(vecs[i].d1);
        end
        drain(8, 40);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_beat%0d", 2 * i), int'(log_at(2 * i)), int'(vecs[i].exp_a));
            check($sformatf("rr_beat%0d", 2 * i + 1), int'(log_at(2 * i + 1)), int'(vecs[i].exp_b));
        end
        check("rr_one_per_cycle", (outcyc.size() == 8) ? outcyc[7] - outcyc[0] : -1, 7);

        // Backpressure on in1.
        outlog.delete();
        ordy = 1'b0;
        drv1.push_back(8'h31);
        drv1.push_back(8'h32);
        drv1.push_back(8'h33);
        for (int k = 0; k < 10 && drv1.size() != 0; k++) tick();
        check("bp_all_accepted", drv1.size(), 0);
        check("bp_in1_full", int'(in1_ready), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_hold_valid", int'(out_valid), 1);
            check("bp_hold_data", int'(out_data), 'h31);
            check("bp_hold_src", int'(out_src), 1);
            check("bp_hold_ready", int'(in1_ready), 0);
        end
        ordy = 1'b1;
        drain(3, 10);
        check("bp_beat0", int'(log_at(0)), 'h131);
        check("bp_beat1", int'(log_at(1)), 'h132);
        check("bp_beat2", int'(log_at(2)), 'h133);

        // Buffer boundary on in0: simultaneous push and pop at count 1.
        outlog.delete();
        ordy = 1'b0;
        drv0.push_back(8'h40);
        drv0.push_back(8'h41);
        tick();
        tick();
        check("bnd_head40", int'(out_data), 'h40);
        check("bnd_cnt1_ready", int'(in0_ready), 1);
        ordy = 1'b1;
        drv0.push_back(8'h42);
        tick();
        check("bnd_pushpop_data", int'(out_data), 'h41);
        check("bnd_pushpop_ready", int'(in0_ready), 1);
        ordy = 1'b0;
        drv0.push_back(8'h43);
        tick();
        check("bnd_cnt2_ready", int'(in0_ready), 0);
        check("bnd_hold41", int'(out_data), 'h41);
        ordy = 1'b1;
        drain(4, 10);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bnd_order%0d", i), int'(log_at(i)), 'h40 + i);
        end
        check("bnd_empty_valid", int'(out_valid), 0);
        tick();
        check("bnd_empty_valid2", int'(out_valid), 0);

        // Reset mid-operation with both buffers full and the output occupied.
        outlog.delete();
        ordy = 1'b0;
        drv0.push_back(8'h61); drv0.push_back(8'h62); drv0.push_back(8'h63);
        drv1.push_back(8'h71); drv1.push_back(8'h72); drv1.push_back(8'h73);
        for (int k = 0; k < 5; k++) tick();
        check("mid_out_valid", int'(out_valid), 1);
        check("mid_in0_full", int'(in0_ready), 0);
        check("mid_in1_full", int'(in1_ready), 0);
        drv0.delete();
        drv1.delete();
        rst = 1'b1;
        tick();
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_data", int'(out_data), 0);
        check("mid_rst_src", int'(out_src), 0);
        check("mid_rst_ready0", int'(in0_ready), 0);
        rst = 1'b0;
        sb0.delete();
        sb1.delete();
        #1;
        check("mid_post_ready0", int'(in0_ready), 1);
        check("mid_post_ready1", int'(in1_ready), 1);
        ordy = 1'b1;
        drv0.push_back(8'h5A);
        drv1.push_back(8'h5B);
        drain(2, 10);
        check("mid_tie_first", int'(log_at(0)), 'h05A);
        check("mid_tie_second", int'(log_at(1)), 'h15B);
        for (int k = 0; k < 3; k++) tick();
        check("mid_no_stale", outlog.size(), 2);
        check("end_sb0_empty", sb0.size(), 0);
        check("end_sb1_empty", sb1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end

endmodule
